seg_scan_ctrl: RTL and testbench

//  Scan controller for the 4-digit multiplexed 7-segment array on the IO board.

---
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment array: digit sequencing, inter-digit
// blanking, brightness PWM and a double-buffered frame write port.
module seg_scan_ctrl #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned BLANK_CYCLES = 256,
   parameter int unsigned STEP_CYCLES  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [8*DIGITS-1:0]   wr_segs,
   input  logic [DIGITS-1:0]     wr_mask,
   input  logic [3:0]            brightness,
   output logic [DIGITS-1:0]     display_sel,
   output logic [7:0]            display,
   output logic                  frame_done
);

   localparam int unsigned CntMax = (BLANK_CYCLES > STEP_CYCLES) ? BLANK_CYCLES : STEP_CYCLES;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [0:0] {StBlank, StOn} state_e;

   state_e                    state_q, state_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic [3:0]                step_q, step_d;
   logic [IdxW-1:0]           idx_q, idx_d;
   logic [3:0]                bright_q, bright_d;
   logic [DIGITS-1:0][7:0]    segs_q, segs_d;
   logic [DIGITS-1:0]         mask_q, mask_d;
   logic [DIGITS-1:0][7:0]    shadow_segs_q, shadow_segs_d;
   logic [DIGITS-1:0]         shadow_mask_q, shadow_mask_d;
   logic                      pending_q, pending_d;
   logic                      wr_ready_q, wr_ready_d;
   logic [DIGITS-1:0]         display_sel_q, display_sel_d;
   logic [7:0]                display_q, display_d;
   logic                      frame_done_q, frame_done_d;
   logic                      boundary;
   logic                      lit;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + 1'b1;
      step_d        = step_q;
      idx_d         = idx_q;
      bright_d      = bright_q;
      segs_d        = segs_q;
      mask_d        = mask_q;
      shadow_segs_d = shadow_segs_q;
      shadow_mask_d = shadow_mask_q;
      pending_d     = pending_q;
      boundary      = 1'b0;

      unique case (state_q)
         StBlank: begin
            if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
               cnt_d   = '0;
               step_d  = 4'd0;
               state_d = StOn;
            end
         end
         StOn: begin
            if (cnt_q == CntW'(STEP_CYCLES - 1)) begin
               cnt_d = '0;
               if (step_q == 4'd14) begin
                  state_d  = StBlank;
                  bright_d = brightness;
                  boundary = (idx_q == IdxW'(DIGITS - 1));
                  idx_d    = boundary ? '0 : idx_q + 1'b1;
               end else begin
                  step_d = step_q + 4'd1;
               end
            end
         end
         default: state_d = StBlank;
      endcase

      // Frames only swap at the wrap so a frame is never shown half-old, half-new.
      if (boundary && pending_q) begin
         segs_d    = shadow_segs_q;
         mask_d    = shadow_mask_q;
         pending_d = 1'b0;
      end

      if (wr_valid && wr_ready_q) begin
         shadow_segs_d = wr_segs;
         shadow_mask_d = wr_mask;
         pending_d     = 1'b1;
      end

      lit           = (state_q == StOn) && (step_q < bright_q) && mask_q[idx_q];
      display_sel_d = lit ? ~(DIGITS'(1) << idx_q) : '1;
      display_d     = lit ? segs_q[idx_q] : 8'hFF;
      frame_done_d  = boundary;
      wr_ready_d    = !pending_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StBlank;
         cnt_q         <= '0;
         step_q        <= 4'd0;
         idx_q         <= '0;
         bright_q      <= 4'd15;
         segs_q        <= '1;
         mask_q        <= '0;
         shadow_segs_q <= '1;
         shadow_mask_q <= '0;
         pending_q     <= 1'b0;
         wr_ready_q    <= 1'b1;
         display_sel_q <= '1;
         display_q     <= 8'hFF;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         step_q        <= step_d;
         idx_q         <= idx_d;
         bright_q      <= bright_d;
         segs_q        <= segs_d;
         mask_q        <= mask_d;
         shadow_segs_q <= shadow_segs_d;
         shadow_mask_q <= shadow_mask_d;
         pending_q     <= pending_d;
         wr_ready_q    <= wr_ready_d;
         display_sel_q <= display_sel_d;
         display_q     <= display_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign wr_ready    = wr_ready_q;
   assign display_sel = display_sel_q;
   assign display     = display_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl; expected pins come from a time-based model of
// slot/frame position rather than from any FSM state.
module tb_seg_scan_ctrl;

   localparam int B     = 2;
   localparam int S     = 1;
   localparam int SLOT  = B + 15 * S;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [31:0] wr_segs = 32'hFFFF_FFFF;
   logic [3:0]  wr_mask = 4'h0;
   logic [3:0]  brightness = 4'd15;
   logic [3:0]  display_sel;
   logic [7:0]  display;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // Model: cycles since release plus the displayed/shadow frame contents.
   int          cyc;
   logic [31:0] m_segs, m_sh_segs;
   logic [3:0]  m_mask, m_sh_mask, m_bright;
   logic        m_pending, m_acc;
   logic [3:0]  exp_sel;
   logic [7:0]  exp_disp;
   logic        exp_fd, exp_rdy;

   seg_scan_ctrl #(.DIGITS(4), .BLANK_CYCLES(B), .STEP_CYCLES(S)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_segs     (wr_segs),
      .wr_mask     (wr_mask),
      .brightness  (brightness),
      .display_sel (display_sel),
      .display     (display),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      int p, idx;
      logic lit;
      m_acc = 1'b0;
      if (reset) begin
         exp_sel = 4'hF; exp_disp = 8'hFF; exp_fd = 1'b0; exp_rdy = 1'b1;
         @(posedge clk); #1;
         cyc = 0; m_segs = 32'hFFFF_FFFF; m_mask = 4'h0; m_bright = 4'd15; m_pending = 1'b0;
         return;
      end
      p        = cyc % SLOT;
      idx      = (cyc / SLOT) % 4;
      lit      = (p >= B) && (((p - B) / S) < int'(m_bright)) && m_mask[idx];
      exp_sel  = lit ? ~(4'b0001 << idx) : 4'hF;
      exp_disp = lit ? m_segs[8*idx +: 8] : 8'hFF;
      exp_fd   = (cyc % FRAME) == FRAME - 1;
      m_acc    = wr_valid && !m_pending;
      if (p == SLOT - 1) m_bright = brightness;
      @(posedge clk); #1;
      if (exp_fd && m_pending) begin
         m_segs = m_sh_segs; m_mask = m_sh_mask; m_pending = 1'b0;
      end
      if (m_acc) begin
         m_sh_segs = wr_segs; m_sh_mask = wr_mask; m_pending = 1'b1;
      end
      exp_rdy = !m_pending;
      cyc++;
   endtask

   task automatic test_reset();
      int first_fd = -1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if ({display_sel, display, frame_done, wr_ready} !== {4'hF, 8'hFF, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got sel=%h disp=%h fd=%b rdy=%b want F/FF/0/1",
                  display_sel, display, frame_done, wr_ready);
      end
      reset = 1'b0;
      for (int n = 1; n <= FRAME + 2; n++) begin
         tick();
         if (frame_done && first_fd < 0) first_fd = n;
         checks++;
         if ({display_sel, display, frame_done, wr_ready} !== {exp_sel, exp_disp, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL reset_run cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc, display_sel,
                     display, frame_done, wr_ready, exp_sel, exp_disp, exp_fd, exp_rdy);
         end
      end
      checks++;
      if (first_fd != FRAME) begin
         errors++;
         $display("FAIL first_frame_done got %0d want %0d", first_fd, FRAME);
      end
   endtask

   task automatic test_digits();
      wr_segs = 32'hC0F9A4B0; wr_mask = 4'hF; brightness = 4'd15; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      for (int n = 0; n < 2 * FRAME; n++) begin
         tick();
         checks++;
         if ({display_sel, display, frame_done, wr_ready} !== {exp_sel, exp_disp, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL digits cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc, display_sel,
                     display, frame_done, wr_ready, exp_sel, exp_disp, exp_fd, exp_rdy);
         end
      end
   endtask

   task automatic test_brightness();
      brightness = 4'd5;
      for (int n = 0; n < 3 * FRAME; n++) begin
         if (n >= FRAME && ($urandom % 7) == 0) brightness = 4'($urandom);
         tick();
         checks++;
         if ({display_sel, display, frame_done, wr_ready} !== {exp_sel, exp_disp, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL brightness cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc, display_sel,
                     display, frame_done, wr_ready, exp_sel, exp_disp, exp_fd, exp_rdy);
         end
      end
   endtask

   task automatic test_mask();
      int last_fd = -1;
      brightness = 4'd15;
      wr_segs = $urandom; wr_mask = 4'b0101; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      for (int n = 0; n < 3 * FRAME; n++) begin
         tick();
         checks++;
         if ({display_sel, display, frame_done, wr_ready} !== {exp_sel, exp_disp, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL mask cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc, display_sel,
                     display, frame_done, wr_ready, exp_sel, exp_disp, exp_fd, exp_rdy);
         end
         if (n > FRAME) begin
            checks++;
            if (!(display_sel inside {4'b1110, 4'b1011, 4'b1111})) begin
               errors++;
               $display("FAIL mask_sel got %b want 1110/1011/1111", display_sel);
            end
         end
         if (frame_done) begin
            if (last_fd >= 0) begin
               checks++;
               if (n - last_fd != FRAME) begin
                  errors++;
                  $display("FAIL mask_period got %0d want %0d", n - last_fd, FRAME);
               end
            end
            last_fd = n;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] seg_b;
      int  fd_at = -1, b_at = -1, n = 0;
      wr_segs = $urandom; wr_mask = 4'hF; wr_valid = 1'b1;
      tick();
      checks++;
      if (wr_ready !== 1'b0 || !m_acc) begin
         errors++;
         $display("FAIL b2b_a_accept got rdy=%b want 0", wr_ready);
      end
      seg_b = $urandom; wr_segs = seg_b; wr_mask = 4'($urandom);
      while (b_at < 0 && n < 3 * FRAME) begin
         tick();
         n++;
         if (frame_done && fd_at < 0) fd_at = n;
         if (m_acc) b_at = n;
         checks++;
         if ({display_sel, display, frame_done, wr_ready} !== {exp_sel, exp_disp, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL b2b_hold cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc, display_sel,
                     display, frame_done, wr_ready, exp_sel, exp_disp, exp_fd, exp_rdy);
         end
      end
      wr_valid = 1'b0;
      checks++;
      if (b_at < 0 || b_at != fd_at + 1) begin
         errors++;
         $display("FAIL b2b_b_accept got %0d want %0d", b_at, fd_at + 1);
      end
      for (int k = 0; k < 2 * FRAME; k++) begin
         tick();
         checks++;
         if ({display_sel, display, frame_done, wr_ready} !== {exp_sel, exp_disp, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL b2b_show cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc, display_sel,
                     display, frame_done, wr_ready, exp_sel, exp_disp, exp_fd, exp_rdy);
         end
      end
   endtask

   task automatic test_reset_pending();
      int guard = 0;
      brightness = 4'd15;
      // Wait for a mid-ON point early in a frame so the write stays pending.
      while (!((cyc % FRAME) == SLOT + B + 3) && guard < 2 * FRAME) begin
         tick();
         guard++;
      end
      wr_segs = $urandom; wr_mask = 4'hF; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({display_sel, display, wr_ready} !== {4'hF, 8'hFF, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid_on got sel=%h disp=%h rdy=%b want F/FF/1",
                  display_sel, display, wr_ready);
      end
      for (int n = 0; n < 2 * FRAME; n++) begin
         tick();
         checks++;
         if ({display_sel, display, frame_done, wr_ready} !== {exp_sel, exp_disp, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL reset_discard cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                     display_sel, display, frame_done, wr_ready, exp_sel, exp_disp, exp_fd, exp_rdy);
         end
      end
   endtask

   task automatic test_random_traffic();
      for (int n = 0; n < 6 * FRAME; n++) begin
         wr_valid   = ($urandom % 5) == 0;
         wr_segs    = $urandom;
         wr_mask    = 4'($urandom);
         if (($urandom % 11) == 0) brightness = 4'($urandom);
         tick();
         checks++;
         if ({display_sel, display, frame_done, wr_ready} !== {exp_sel, exp_disp, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL random cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc, display_sel,
                     display, frame_done, wr_ready, exp_sel, exp_disp, exp_fd, exp_rdy);
         end
      end
      wr_valid = 1'b0;
   endtask

   initial begin
      cyc = 0; m_segs = '1; m_sh_segs = '1; m_mask = '0; m_sh_mask = '0;
      m_bright = 4'd15; m_pending = 1'b0;
      test_reset();
      test_digits();
      test_brightness();
      test_mask();
      test_back_to_back();
      test_reset_pending();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
